border_mask: RTL and testbench
==============================

BORDER_MASK -- requirements
Module: border_mask

Interface
REQ-001 SHALL have parameter BORDER, default 2, border width in pixels and lines to blank (5x5 kernel half-size).
REQ-002 SHALL have parameter CW, default 12, width of the column, row and measurement counters.
REQ-003 SHALL have port clk  input  1  single system clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports rx_red/rx_green/rx_blue  input  8 each  filtered pixel from convolution stage.
REQ-006 SHALL have ports rx_dv, rx_hs, rx_vs  input  1 each  data-valid, hsync, vsync aligned with the pixel.
REQ-007 SHALL have ports tx_red/tx_green/tx_blue  output  8 each  masked pixel.
REQ-008 SHALL have ports tx_dv, tx_hs, tx_vs  output  1 each  delayed copies of rx_dv/rx_hs/rx_vs.
REQ-009 SHALL have ports meas_width, meas_height  output  CW each  last complete line length and frame height in active pixels/lines.

Function
REQ-010 SHALL register all outputs, giving a fixed latency of exactly 1 clk from any input to the matching output.
REQ-011 SHALL pass tx_dv/tx_hs/tx_vs unchanged apart from the 1-cycle delay.
REQ-012 SHALL keep a column counter: 0 on the first rx_dv=1 cycle after rx_dv=0, +1 on each further rx_dv=1 cycle, saturating at 2^CW-1.
REQ-013 SHALL keep a row counter: +1 on each rx_dv falling edge, cleared to 0 on each rx_vs rising edge, saturating at 2^CW-1.
REQ-014 SHALL latch line length (column count + 1) into the width register on each rx_dv falling edge.
REQ-015 SHALL latch the row count into the height register on each rx_vs rising edge, then clear the row counter.
REQ-016 SHALL treat a simultaneous rx_dv falling edge and rx_vs rising edge as: line counted first, then height latched with that line included, row cleared.
REQ-017 SHALL force tx colour outputs to 0 when col < BORDER or row < BORDER.
REQ-018 SHALL also force 0 when width register is valid and col >= width-BORDER, or height register valid and row >= height-BORDER.
REQ-019 SHALL consider a measurement valid only when non-zero and >= 2*BORDER+1; otherwise right/bottom masking is disabled.
REQ-020 SHALL force tx colour outputs to 0 whenever rx_dv=0.
REQ-021 SHALL pass colour unchanged when none of the mask conditions hold.
REQ-022 SHALL use subtractions at CW bits with no wrap: comparisons only performed when the valid condition of REQ-019 holds.

Reset
REQ-023 SHALL on rst=1 asynchronously clear all tx outputs, counters, width/height registers and edge-detect flops to 0.
REQ-024 SHALL, after rst deasserts mid-frame, mask top/left borders relative to the next detected line/frame start and disable right/bottom masking until first valid measurement.

Configuration
REQ-025 SHALL honour macro BORDER_MASK_STATS_EN: defined -> meas_width/meas_height drive the width/height registers.
REQ-026 SHALL, with BORDER_MASK_STATS_EN undefined, tie meas_width/meas_height to 0; masking behaviour identical in both builds.

Structure
REQ-027 SHALL place default BORDER, CW and the masked colour value (8'h00) as constants in shared package video_pkg.
REQ-028 SHALL implement edge detection of rx_dv/rx_vs in one sub-module, edge_det, instantiated twice.
REQ-029 SHALL remain a single clock domain with no BRAM or DSP usage.

Verification
REQ-030 SHALL test: reset, then 3 frames of 10 lines x 16 pixels of value 8'hAA -> from frame 2, rows 0-1, 8-9 and cols 0-1, 14-15 output 0, interior 8'hAA, latency 1 clk.
REQ-031 SHALL test: first frame after reset -> only rows 0-1 and cols 0-1 masked on line 1; right-edge masking starts on line 2 (width 16 valid).
REQ-032 SHALL test: line length change 16->20 mid-frame -> the next line masks cols 14-15, the following one masks cols 18-19.
REQ-033 SHALL test: rst asserted at pixel 7 of line 4 -> all outputs 0 within the same cycle, meas_width/meas_height 0 afterwards until re-measured.
REQ-034 SHALL test: 4-pixel line (< 2*BORDER+1) -> width invalid, only left border masked; meas_width=4 with BORDER_MASK_STATS_EN, 0 without.
REQ-035 SHALL test: rx_dv falling edge coincident with rx_vs rising edge after 10 lines -> meas_height=10, row counter 0 next cycle.

Source files
------------

// File: rtl/video_pkg.sv
// Shared video constants and pixel type for the post-convolution pixel path.
// Defaults match a 5x5 kernel (half-size 2) and 12-bit geometry counters.
package video_pkg;

    localparam int         BORDER_DEF = 2;
    localparam int         CW_DEF     = 12;
    localparam logic [7:0] MASK_VAL   = 8'h00;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage

// File: rtl/edge_det.sv
// Single-bit edge detector: remembers last cycle's level and flags rise/fall combinationally.
// Latency 0 from d_i to rise_o/fall_o; no backpressure.
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    assign rise_o = d_i & ~d_q;
    assign fall_o = ~d_i & d_q;

endmodule

// File: rtl/border_mask.sv
// Blanks the BORDER-wide frame edge a 5x5 filter cannot compute, measuring line/frame size on the fly.
// Latency 1 clk; no backpressure. Macro BORDER_MASK_STATS_EN exposes the measured width/height.
module border_mask
    import video_pkg::*;
#(
    parameter int BORDER = BORDER_DEF,
    parameter int CW     = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_red,
    input  logic [7:0]    rx_green,
    input  logic [7:0]    rx_blue,
    input  logic          rx_dv,
    input  logic          rx_hs,
    input  logic          rx_vs,
    output logic [7:0]    tx_red,
    output logic [7:0]    tx_green,
    output logic [7:0]    tx_blue,
    output logic          tx_dv,
    output logic          tx_hs,
    output logic          tx_vs,
    output logic [CW-1:0] meas_width,
    output logic [CW-1:0] meas_height
);

    localparam logic [CW-1:0] CMAX     = '1;
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] B_W      = CW'(BORDER);
    localparam logic [CW-1:0] MIN_MEAS = CW'(2 * BORDER + 1);

    logic dv_rise, dv_fall, vs_rise, vs_fall_unused;

    edge_det u_dv_edge (
        .clk    (clk),
        .rst    (rst),
        .d_i    (rx_dv),
        .rise_o (dv_rise),
        .fall_o (dv_fall)
    );

    edge_det u_vs_edge (
        .clk    (clk),
        .rst    (rst),
        .d_i    (rx_vs),
        .rise_o (vs_rise),
        .fall_o (vs_fall_unused)
    );

    logic [CW-1:0] col_q, col_d, row_q, row_d;
    logic [CW-1:0] width_q, width_d, height_q, height_d;
    logic [CW-1:0] col_cur, row_cur, row_inc;
    logic          w_ok, h_ok, mask;
    rgb_t          pix_q, pix_d;
    logic          tx_dv_q, tx_hs_q, tx_vs_q;

    always_comb begin
        col_cur  = dv_rise ? '0 : ((col_q == CMAX) ? CMAX : col_q + ONE);
        row_cur  = vs_rise ? '0 : row_q;
        // A line ending in the same cycle vsync rises still belongs to the closing frame.
        row_inc  = (dv_fall && (row_q != CMAX)) ? row_q + ONE : row_q;

        // Subtractions below are only evaluated when the measurement guarantees no wrap.
        w_ok = (width_q  != '0) && (width_q  >= MIN_MEAS);
        h_ok = (height_q != '0) && (height_q >= MIN_MEAS);

        mask = !rx_dv
            || (col_cur < B_W)
            || (row_cur < B_W)
            || (w_ok && (col_cur >= width_q  - B_W))
            || (h_ok && (row_cur >= height_q - B_W));

        col_d    = rx_dv ? col_cur : col_q;
        width_d  = dv_fall ? ((col_q == CMAX) ? CMAX : col_q + ONE) : width_q;
        row_d    = vs_rise ? '0 : row_inc;
        height_d = vs_rise ? row_inc : height_q;

        if (mask) begin
            pix_d = '{r: MASK_VAL, g: MASK_VAL, b: MASK_VAL};
        end else begin
            pix_d = '{r: rx_red, g: rx_green, b: rx_blue};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q    <= '0;
            row_q    <= '0;
            width_q  <= '0;
            height_q <= '0;
            pix_q    <= '0;
            tx_dv_q  <= 1'b0;
            tx_hs_q  <= 1'b0;
            tx_vs_q  <= 1'b0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            width_q  <= width_d;
            height_q <= height_d;
            pix_q    <= pix_d;
            tx_dv_q  <= rx_dv;
            tx_hs_q  <= rx_hs;
            tx_vs_q  <= rx_vs;
        end
    end

    assign tx_red   = pix_q.r;
    assign tx_green = pix_q.g;
    assign tx_blue  = pix_q.b;
    assign tx_dv    = tx_dv_q;
    assign tx_hs    = tx_hs_q;
    assign tx_vs    = tx_vs_q;

`ifdef BORDER_MASK_STATS_EN
    assign meas_width  = width_q;
    assign meas_height = height_q;
`else
    assign meas_width  = '0;
    assign meas_height = '0;
`endif

endmodule

// File: tb/tb_border_mask.sv
// Self-checking bench for border_mask: hand-computed vector table, directed frame scenarios,
// and randomized video checked against a pixel-position reference model.
module tb_border_mask;
    import video_pkg::*;

    localparam int BORDER = 2;
    localparam int CW     = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_red, rx_green, rx_blue;
    logic          rx_dv, rx_hs, rx_vs;
    logic [7:0]    tx_red, tx_green, tx_blue;
    logic          tx_dv, tx_hs, tx_vs;
    logic [CW-1:0] meas_width, meas_height;

    always #5 clk = ~clk;

    border_mask #(.BORDER(BORDER), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_red      (rx_red),
        .rx_green    (rx_green),
        .rx_blue     (rx_blue),
        .rx_dv       (rx_dv),
        .rx_hs       (rx_hs),
        .rx_vs       (rx_vs),
        .tx_red      (tx_red),
        .tx_green    (tx_green),
        .tx_blue     (tx_blue),
        .tx_dv       (tx_dv),
        .tx_hs       (tx_hs),
        .tx_vs       (tx_vs),
        .meas_width  (meas_width),
        .meas_height (meas_height)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: position of the current pixel inside its line and frame,
    // plus the last completed line length and frame height.
    bit m_prev_dv, m_prev_vs;
    int m_run_len, m_row, m_last_len, m_last_height;

    task automatic m_reset();
        m_prev_dv = 0; m_prev_vs = 0;
        m_run_len = 0; m_row = 0; m_last_len = 0; m_last_height = 0;
    endtask

    function automatic bit meas_ok(input int m);
        return (m != 0) && (m >= 2 * BORDER + 1);
    endfunction

    function automatic int exp_meas(input int m);
`ifdef BORDER_MASK_STATS_EN
        return m;
`else
        return 0 * m;
`endif
    endfunction

    function automatic int stats_only(input int v);
`ifdef BORDER_MASK_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic step(input bit dv, input bit hs, input bit vs, input logic [23:0] pix);
        int col, row;
        bit masked;
        logic [23:0] e_pix;
        rx_dv = dv; rx_hs = hs; rx_vs = vs;
        {rx_red, rx_green, rx_blue} = pix;
        col = (dv && !m_prev_dv) ? 0 : m_run_len;
        row = (vs && !m_prev_vs) ? 0 : m_row;
        masked = !dv || (col < BORDER) || (row < BORDER)
              || (meas_ok(m_last_len)    && col >= m_last_len - BORDER)
              || (meas_ok(m_last_height) && row >= m_last_height - BORDER);
        e_pix = masked ? 24'h0 : pix;
        @(posedge clk); #1;
        chk("pixel", {8'h0, tx_red, tx_green, tx_blue}, {8'h0, e_pix});
        chk("sync", {29'h0, tx_dv, tx_hs, tx_vs}, {29'h0, dv, hs, vs});
        if (dv) m_run_len = col + 1;
        if (!dv && m_prev_dv) begin
            m_last_len = m_run_len;
            m_row++;
        end
        if (vs && !m_prev_vs) begin
            m_last_height = m_row;
            m_row = 0;
        end
        m_prev_dv = dv; m_prev_vs = vs;
        chk("meas_width",  32'(meas_width),  32'(exp_meas(m_last_len)));
        chk("meas_height", 32'(meas_height), 32'(exp_meas(m_last_height)));
    endtask

    task automatic send_line(input int len, input int blank, input bit rnd, input logic [23:0] pix);
        for (int c = 0; c < len; c++) step(1'b1, 1'b0, 1'b0, rnd ? 24'($urandom) : pix);
        for (int b = 0; b < blank; b++) step(1'b0, b == 0, 1'b0, 24'h0);
    endtask

    task automatic vsync();
        step(1'b0, 1'b0, 1'b1, 24'h0);
        step(1'b0, 1'b0, 1'b1, 24'h0);
        step(1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_dv = 0; rx_hs = 0; rx_vs = 0; {rx_red, rx_green, rx_blue} = 24'h0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_pixel", {8'h0, tx_red, tx_green, tx_blue}, 32'h0);
        chk("rst_sync",  {29'h0, tx_dv, tx_hs, tx_vs}, 32'h0);
        chk("rst_meas",  {8'h0, meas_width, meas_height}, 32'h0);
        rst = 1'b0;
        m_reset();
    endtask

    typedef struct {
        logic        dv;
        logic [23:0] pix;
        logic [23:0] exp_pix;
    } vec_t;

    vec_t tbl[21];

    initial begin
        // Three 6-pixel lines, one blank cycle apart, straight after reset.
        // Rows 0/1 are fully blanked; row 2 passes only cols 2 and 3 (width 6 -> cols >= 4 blanked).
        for (int i = 0; i < 21; i++) begin
            tbl[i].dv      = (i % 7) != 6;
            tbl[i].pix     = 24'h102030 + 24'(i);
            tbl[i].exp_pix = 24'h0;
        end
        tbl[16].exp_pix = 24'h102040;
        tbl[17].exp_pix = 24'h102041;

        rst = 1'b1;
        rx_dv = 0; rx_hs = 0; rx_vs = 0; {rx_red, rx_green, rx_blue} = 24'h0;
        m_reset();
        #1;
        chk("por_pixel", {8'h0, tx_red, tx_green, tx_blue}, 32'h0);
        do_reset();

        for (int i = 0; i < 21; i++) begin
            rx_dv = tbl[i].dv; rx_hs = 0; rx_vs = 0;
            {rx_red, rx_green, rx_blue} = tbl[i].pix;
            @(posedge clk); #1;
            chk($sformatf("table_pix[%0d]", i), {8'h0, tx_red, tx_green, tx_blue}, {8'h0, tbl[i].exp_pix});
            chk($sformatf("table_dv[%0d]", i), {31'h0, tx_dv}, {31'h0, tbl[i].dv});
        end
        chk("table_meas_width", 32'(meas_width), 32'(stats_only(6)));

        // Three frames of 10x16 flat 0xAA pixels.
        do_reset();
        for (int f = 0; f < 3; f++) begin
            vsync();
            for (int l = 0; l < 10; l++) send_line(16, 4, 1'b0, 24'hAAAAAA);
        end
        vsync();
        chk("frames_meas_width",  32'(meas_width),  32'(stats_only(16)));
        chk("frames_meas_height", 32'(meas_height), 32'(stats_only(10)));

        // Line length change 16 -> 20 mid-frame.
        for (int l = 0; l < 5; l++) send_line(16, 3, 1'b1, 24'h0);
        for (int l = 0; l < 4; l++) send_line(20, 3, 1'b1, 24'h0);
        chk("resize_meas_width", 32'(meas_width), 32'(stats_only(20)));

        // Reset at pixel 7 of line 4.
        vsync();
        for (int l = 0; l < 4; l++) send_line(16, 3, 1'b0, 24'h5A5A5A);
        for (int c = 0; c < 7; c++) step(1'b1, 1'b0, 1'b0, 24'h5A5A5A);
        rx_dv = 1'b1; {rx_red, rx_green, rx_blue} = 24'h5A5A5A;
        rst = 1'b1;
        #1;
        chk("midrst_pixel", {8'h0, tx_red, tx_green, tx_blue}, 32'h0);
        chk("midrst_sync",  {29'h0, tx_dv, tx_hs, tx_vs}, 32'h0);
        chk("midrst_meas",  {8'h0, meas_width, meas_height}, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rx_dv = 1'b0;
        rst = 1'b0;
        m_reset();
        for (int l = 0; l < 5; l++) send_line(16, 3, 1'b1, 24'h0);
        vsync();
        for (int l = 0; l < 10; l++) send_line(16, 3, 1'b1, 24'h0);
        vsync();

        // Lines narrower than 2*BORDER+1: only left/top borders apply.
        do_reset();
        vsync();
        for (int l = 0; l < 4; l++) send_line(4, 2, 1'b0, 24'h555555);
        chk("narrow_meas_width", 32'(meas_width), 32'(stats_only(4)));

        // Last line's dv fall coincides with vsync rise.
        vsync();
        for (int l = 0; l < 9; l++) send_line(16, 3, 1'b1, 24'h0);
        send_line(16, 0, 1'b1, 24'h0);
        step(1'b0, 1'b0, 1'b1, 24'h0);
        chk("coinc_meas_height", 32'(meas_height), 32'(stats_only(10)));
        step(1'b0, 1'b0, 1'b1, 24'h0);
        step(1'b0, 1'b0, 1'b0, 24'h0);
        for (int l = 0; l < 3; l++) send_line(16, 3, 1'b0, 24'h777777);

        // Randomized video timing.
        do_reset();
        for (int f = 0; f < 6; f++) begin
            int lines;
            vsync();
            lines = $urandom_range(3, 12);
            for (int l = 0; l < lines; l++)
                send_line($urandom_range(3, 24), $urandom_range(1, 4), 1'b1, 24'h0);
        end
        vsync();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
